// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM states, parity modes, oversampling default
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int OVS_DEFAULT = 16;

  // Mode 2'b11 is treated as "no parity", same as PAR_NONE.
  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_param_if.sv
// rtl/uart_tx_fifo_param_if.sv - host write handshake into the UART transmit FIFO
interface uart_tx_fifo_param_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] Tx_DATA;
  logic              Tx_WR;
  logic              Tx_RDY;

  modport master (output Tx_DATA, output Tx_WR, input Tx_RDY);
  modport slave  (input Tx_DATA, input Tx_WR, output Tx_RDY);
endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - baud tick generator, one tick every baud_div+1 clocks, held while clr
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // Free-running divider; clearing keeps the first tick a full period after clr drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt == baud_div) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clr && (cnt == baud_div);

endmodule

// File: rtl/uart_tx_fifo_param.sv
// rtl/uart_tx_fifo_param.sv - UART transmitter with input FIFO; UART_TX_BREAK_EN adds tx_break
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int OVS    = OVS_DEFAULT,
  parameter int DIV_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DIV_W-1:0]       baud_div,
  input  logic [1:0]             par_mode,
  input  logic                   two_stop,
  input  logic                   Tx_EN,
`ifdef UART_TX_BREAK_EN
  input  logic                   tx_break,
`endif
  uart_tx_fifo_param_if.slave    wr,
  output logic                   TxD,
  output logic                   Tx_BUSY,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TICK_W = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int IDX_W  = $clog2(DATA_W);

  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVS - 1);
  localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              pop;

  uart_state_t       state;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              par_en;
  logic              stop2;
  logic              stop_hi;
  logic [TICK_W-1:0] bit_tick;
  logic [IDX_W-1:0]  bit_idx;
  logic              idle;
  logic              clr;
  logic              tick;

`ifdef UART_TX_BREAK_EN
  logic              brk_on;
  logic              brk_mark;
  logic              mark_done;
`endif

  assign head       = mem[rd_ptr];
  assign idle       = (state == ST_IDLE);
  assign wr.Tx_RDY  = (count != FULL_CNT);
  assign push       = wr.Tx_WR && wr.Tx_RDY;
  assign fifo_count = count;

`ifdef UART_TX_BREAK_EN
  // After a break the line must show one full mark bit before the next start bit.
  assign mark_done = brk_mark && tick && (bit_tick == LAST_TICK);
  assign pop       = idle && Tx_EN && (count != '0) && !tx_break && !brk_on &&
                     (!brk_mark || mark_done);
  assign clr       = idle && !brk_mark;
  assign Tx_BUSY   = !idle || (count != '0) || tx_break || brk_on || brk_mark;
`else
  assign pop       = idle && Tx_EN && (count != '0);
  assign clr       = idle;
  assign Tx_BUSY   = !idle || (count != '0);
`endif

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .baud_div (baud_div),
    .tick     (tick)
  );

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr.Tx_DATA;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer; TxD is registered and set on each bit boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      TxD      <= 1'b1;
      shreg    <= '0;
      par_bit  <= 1'b0;
      par_en   <= 1'b0;
      stop2    <= 1'b0;
      stop_hi  <= 1'b0;
      bit_tick <= '0;
      bit_idx  <= '0;
`ifdef UART_TX_BREAK_EN
      brk_on   <= 1'b0;
      brk_mark <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shreg    <= head;
            par_bit  <= (^head) ^ (par_mode == PAR_ODD);
            par_en   <= parity_on(par_mode);
            stop2    <= two_stop;
            stop_hi  <= 1'b0;
            bit_tick <= '0;
            bit_idx  <= '0;
            TxD      <= 1'b0;
            state    <= ST_START;
`ifdef UART_TX_BREAK_EN
            brk_mark <= 1'b0;
`endif
          end
`ifdef UART_TX_BREAK_EN
          else if (tx_break) begin
            TxD      <= 1'b0;
            brk_on   <= 1'b1;
            brk_mark <= 1'b0;
          end else if (brk_on) begin
            TxD      <= 1'b1;
            brk_on   <= 1'b0;
            brk_mark <= 1'b1;
            bit_tick <= '0;
          end else if (brk_mark && tick) begin
            if (bit_tick == LAST_TICK) begin
              bit_tick <= '0;
              brk_mark <= 1'b0;
            end else begin
              bit_tick <= bit_tick + 1'b1;
            end
          end
`endif
        end
        default: begin
          if (tick) begin
            if (bit_tick != LAST_TICK) begin
              bit_tick <= bit_tick + 1'b1;
            end else begin
              bit_tick <= '0;
              case (state)
                ST_START: begin
                  state <= ST_DATA;
                  TxD   <= shreg[0];
                end
                ST_DATA: begin
                  if (bit_idx == LAST_BIT) begin
                    if (par_en) begin
                      state <= ST_PARITY;
                      TxD   <= par_bit;
                    end else begin
                      state <= ST_STOP;
                      TxD   <= 1'b1;
                    end
                  end else begin
                    bit_idx <= bit_idx + 1'b1;
                    shreg   <= shreg >> 1;
                    TxD     <= shreg[1];
                  end
                end
                ST_PARITY: begin
                  state <= ST_STOP;
                  TxD   <= 1'b1;
                end
                ST_STOP: begin
                  if (stop2 && !stop_hi) begin
                    stop_hi <= 1'b1;
                  end else begin
                    state <= ST_IDLE;
                  end
                end
                default: state <= ST_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb/tb_uart_tx_fifo_param.sv - directed self-checking bench for uart_tx_fifo_param
module tb_uart_tx_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [15:0] a_baud_div;
  logic [1:0]  a_par_mode;
  logic        a_two_stop;
  logic        a_en;
  logic        a_txd;
  logic        a_busy;
  logic [2:0]  a_count;

  logic [15:0] b_baud_div;
  logic [1:0]  b_par_mode;
  logic        b_two_stop;
  logic        b_en;
  logic        b_txd;
  logic        b_busy;
  logic [2:0]  b_count;

`ifdef UART_TX_BREAK_EN
  logic        a_brk;
  logic        b_brk;
`endif

  uart_tx_fifo_param_if #(.DATA_W(8)) a_if ();
  uart_tx_fifo_param_if #(.DATA_W(7)) b_if ();

  uart_tx_fifo_param #(.DATA_W(8), .DEPTH(4), .OVS(16), .DIV_W(16)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .baud_div   (a_baud_div),
    .par_mode   (a_par_mode),
    .two_stop   (a_two_stop),
    .Tx_EN      (a_en),
`ifdef UART_TX_BREAK_EN
    .tx_break   (a_brk),
`endif
    .wr         (a_if),
    .TxD        (a_txd),
    .Tx_BUSY    (a_busy),
    .fifo_count (a_count)
  );

  uart_tx_fifo_param #(.DATA_W(7), .DEPTH(4), .OVS(16), .DIV_W(16)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .baud_div   (b_baud_div),
    .par_mode   (b_par_mode),
    .two_stop   (b_two_stop),
    .Tx_EN      (b_en),
`ifdef UART_TX_BREAK_EN
    .tx_break   (b_brk),
`endif
    .wr         (b_if),
    .TxD        (b_txd),
    .Tx_BUSY    (b_busy),
    .fifo_count (b_count)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  par;
    logic        two;
    int          nbits;
    logic [15:0] bits;   // line bits, first bit sent at position nbits-1
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [7:0] d);
    a_if.Tx_DATA = d;
    a_if.Tx_WR   = 1'b1;
    step();
    a_if.Tx_WR   = 1'b0;
  endtask

  // Called one cycle after the pop edge; checks first/last cycle of every bit and Tx_BUSY fall.
  task automatic check_frame(input bit sel_b, input int n, input int blen, input logic [15:0] bits);
    for (int j = 0; j <= n * blen; j++) begin
      logic t;
      logic b;
      t = sel_b ? b_txd : a_txd;
      b = sel_b ? b_busy : a_busy;
      if (j < n * blen && ((j % blen) == 0 || (j % blen) == blen - 1))
        check("txd_bit", {31'd0, t}, {31'd0, bits[n - 1 - j / blen]});
      if (j == n * blen - 1) check("busy_last_cycle", {31'd0, b}, 32'd1);
      if (j == n * blen) begin
        check("busy_after_frame", {31'd0, b}, 32'd0);
        check("txd_after_frame", {31'd0, t}, 32'd1);
      end
      if (j < n * blen) step();
    end
  endtask

  initial begin
    logic [7:0] got;

    vecs[0] = '{8'hA5, 2'b01, 1'b0, 11, 16'b00000_01010010101};
    vecs[1] = '{8'h00, 2'b00, 1'b0, 10, 16'b000000_0000000001};
    vecs[2] = '{8'hFF, 2'b10, 1'b1, 12, 16'b0000_011111111111};
    vecs[3] = '{8'h01, 2'b01, 1'b1, 12, 16'b0000_010000000111};
    vecs[4] = '{8'h80, 2'b11, 1'b0, 10, 16'b000000_0000000011};
    vecs[5] = '{8'h3C, 2'b10, 1'b0, 11, 16'b00000_00011110011};

    reset       = 1'b0;
    a_baud_div  = 16'd0;
    a_par_mode  = 2'b01;
    a_two_stop  = 1'b0;
    a_en        = 1'b1;
    a_if.Tx_DATA = 8'h00;
    a_if.Tx_WR  = 1'b0;
    b_baud_div  = 16'd3;
    b_par_mode  = 2'b10;
    b_two_stop  = 1'b1;
    b_en        = 1'b1;
    b_if.Tx_DATA = 7'h00;
    b_if.Tx_WR  = 1'b0;
`ifdef UART_TX_BREAK_EN
    a_brk       = 1'b0;
    b_brk       = 1'b0;
`endif

    // Reset state and 1000 idle cycles with no writes.
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      check("idle_txd", {31'd0, a_txd}, 32'd1);
      check("idle_rdy", {31'd0, a_if.Tx_RDY}, 32'd1);
      check("idle_busy", {31'd0, a_busy}, 32'd0);
      check("idle_count", {29'd0, a_count}, 32'd0);
      step();
    end

    // Table of single frames at baud_div=0; vector 0 is 0xA5, even parity, one stop.
    for (int v = 0; v < 6; v++) begin
      a_par_mode = vecs[v].par;
      a_two_stop = vecs[v].two;
      write_a(vecs[v].data);
      check("count_after_push", {29'd0, a_count}, 32'd1);
      step();
      check("count_after_pop", {29'd0, a_count}, 32'd0);
      check_frame(1'b0, vecs[v].nbits, 16, vecs[v].bits);
    end

    // FIFO fill with transmitter disabled; the last two writes must be dropped.
    a_en       = 1'b0;
    a_par_mode = 2'b00;
    a_two_stop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_if.Tx_DATA = 8'(8'h11 * (i + 1));
      a_if.Tx_WR   = 1'b1;
      check("fill_rdy", {31'd0, a_if.Tx_RDY}, (i < 4) ? 32'd1 : 32'd0);
      step();
    end
    a_if.Tx_WR = 1'b0;
    check("full_count", {29'd0, a_count}, 32'd4);
    check("full_rdy", {31'd0, a_if.Tx_RDY}, 32'd0);
    check("full_busy", {31'd0, a_busy}, 32'd1);
    check("full_txd", {31'd0, a_txd}, 32'd1);
    a_en = 1'b1;
    step();
    got = 8'h00;
    for (int j = 0; j < 4 * 161; j++) begin
      int f;
      int o;
      f = j / 161;
      o = j % 161;
      if (o == 0) begin
        check("drain_start", {31'd0, a_txd}, 32'd0);
        check("drain_count", {29'd0, a_count}, 32'(3 - f));
        got = 8'h00;
      end
      if (o >= 24 && o <= 136 && ((o - 24) % 16) == 0) got[(o - 24) / 16] = a_txd;
      if (o == 152) begin
        check("drain_stop", {31'd0, a_txd}, 32'd1);
        check("drain_data", {24'd0, got}, 32'(8'h11 * (f + 1)));
      end
      if (o == 160) check("drain_gap", {31'd0, a_txd}, 32'd1);
      step();
    end
    check("drain_done_busy", {31'd0, a_busy}, 32'd0);

    // Push and pop on the same edge, then asynchronous reset in the middle of DATA.
    a_en = 1'b0;
    write_a(8'h5A);
    a_if.Tx_DATA = 8'hC3;
    a_if.Tx_WR   = 1'b1;
    a_en         = 1'b1;
    step();
    a_if.Tx_WR   = 1'b0;
    check("pushpop_count", {29'd0, a_count}, 32'd1);
    check("pushpop_start", {31'd0, a_txd}, 32'd0);
    for (int i = 0; i < 48; i++) step();
    check("mid_data_txd", {31'd0, a_txd}, 32'd0);
    check("mid_data_count", {29'd0, a_count}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_txd", {31'd0, a_txd}, 32'd1);
    check("abort_count", {29'd0, a_count}, 32'd0);
    check("abort_busy", {31'd0, a_busy}, 32'd0);
    check("abort_rdy", {31'd0, a_if.Tx_RDY}, 32'd1);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      check("post_reset_txd", {31'd0, a_txd}, 32'd1);
      step();
    end
    check("post_reset_count", {29'd0, a_count}, 32'd0);

    // DATA_W=7, odd parity, two stop bits, baud_div=3: 11 bits of 64 clocks.
    b_if.Tx_DATA = 7'h00;
    b_if.Tx_WR   = 1'b1;
    step();
    b_if.Tx_WR   = 1'b0;
    check("b_count_push", {29'd0, b_count}, 32'd1);
    step();
    check_frame(1'b1, 11, 64, 16'b00000_00000000111);

`ifdef UART_TX_BREAK_EN
    // Break held for 100 clocks with a frame queued, then one mark bit, then the frame.
    a_par_mode = 2'b00;
    a_two_stop = 1'b0;
    a_brk      = 1'b1;
    step();
    write_a(8'h96);
    for (int i = 0; i < 100; i++) begin
      check("break_txd", {31'd0, a_txd}, 32'd0);
      check("break_busy", {31'd0, a_busy}, 32'd1);
      step();
    end
    a_brk = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      check("break_mark", {31'd0, a_txd}, 32'd1);
      step();
    end
    check_frame(1'b0, 10, 16, 16'b000000_0011010011);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
